// File: rtl/dmem_mmio_bridge.sv
// Data-memory / MMIO bridge: decodes a 16-word MMIO window into a byte TX FIFO, status and cycle counter.
// Optional feature: define MMIO_CYCLE_COUNTER_EN to build the free-running CYCLE register.
module dmem_mmio_bridge #(
    parameter logic [7:0] MMIO_BASE  = 8'hFF,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             hit;
    logic [3:0]       offset;
    logic             push;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             ovf_clear;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             sel_reg;
    logic [31:0]      rd_reg;
    logic [31:0]      rd_next;
    logic [31:0]      status_word;
    logic [31:0]      cycle_value;
    logic [7:0]       fifo_mem [FIFO_DEPTH];

    assign hit    = (address_dmem[11:4] == MMIO_BASE);
    assign offset = address_dmem[3:0];

    // The syncram always sees the raw address/data; only its write strobe is gated.
    assign mem_address = address_dmem;
    assign mem_data    = data;
    assign mem_wren    = wren & ~hit;

    assign full      = (cnt_reg == CNT_W'(FIFO_DEPTH));
    assign empty     = (cnt_reg == '0);
    assign push      = hit & wren & (offset == 4'd0);
    assign pop       = tx_valid & tx_ready;
    // Fullness is judged on the pre-edge count, so a simultaneous pop does not rescue the push.
    assign push_ok   = push & ~full;
    assign drop      = push & full;
    assign ovf_clear = hit & wren & (offset == 4'd1) & data[2];

    assign tx_valid = ~empty;
    assign tx_data  = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= data[7:0];
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({push_ok, pop})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    // A drop on the same edge as a clear wins, so no overflow is ever lost.
    always_comb begin
        ovf_next = ovf_reg;
        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clear) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end

    assign cycle_value = cycle_reg;
`else
    assign cycle_value = '0;
`endif

    assign status_word = {16'h0000, {(8 - CNT_W){1'b0}}, cnt_reg, 5'b00000, ovf_reg, empty, full};

    always_comb begin
        rd_next = '0;
        case (offset)
            4'd1:    rd_next = status_word;
            4'd2:    rd_next = cycle_value;
            default: rd_next = '0;
        endcase
    end

    // Capture pre-edge register state to match the syncram's one-cycle read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_reg <= 1'b0;
            rd_reg  <= '0;
        end else begin
            sel_reg <= hit;
            rd_reg  <= rd_next;
        end
    end

    assign q_dmem = sel_reg ? rd_reg : mem_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge with a behavioural syncram on the mem_* side.
// Build with MMIO_CYCLE_COUNTER_EN defined to exercise the CYCLE register and its wrap.
module tb_dmem_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ram [0:4095];

    always #5 clock = ~clock;

    dmem_mmio_bridge #(
        .MMIO_BASE (8'hFF),
        .FIFO_DEPTH(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .q_dmem      (q_dmem),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    // Syncram model: registered read, write-first is not needed for these vectors.
    always @(posedge clock) begin
        if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        mem_q <= ram[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [11:0] addr, input logic [31:0] wdata);
        address_dmem = addr;
        data         = wdata;
        wren         = 1'b1;
        tick();
        wren = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] addr, output logic [31:0] rdata);
        address_dmem = addr;
        wren         = 1'b0;
        tick();
        rdata = q_dmem;
    endtask

    logic [31:0] rv;
    logic [31:0] c1;

    initial begin
        address_dmem = 12'h000;
        data         = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset q_dmem=mem_q", q_dmem, mem_q);
        reset = 1'b0;
        tick();

        bus_read(12'hFF1, rv);
        check("reset STATUS", rv, 32'h0000_0002);

        // 1: plain dmem write/read
        address_dmem = 12'h010;
        data         = 32'h0000_0123;
        wren         = 1'b1;
        #1;
        check("t1 mem_wren on write", {31'h0, mem_wren}, 32'h1);
        check("t1 mem_address pass", {20'h0, mem_address}, 32'h010);
        check("t1 mem_data pass", mem_data, 32'h0000_0123);
        tick();
        wren = 1'b0;
        bus_read(12'h010, rv);
        check("t1 dmem readback", rv, 32'h0000_0123);

        // 2: two pushes, status, drain
        tx_ready     = 1'b0;
        address_dmem = 12'hFF0;
        data         = 32'h0000_0041;
        wren         = 1'b1;
        #1;
        check("t2 mem_wren blocked", {31'h0, mem_wren}, 32'h0);
        tick();
        bus_write(12'hFF0, 32'h0000_0042);
        bus_read(12'hFF1, rv);
        check("t2 STATUS cnt2", rv, 32'h0000_0200);
        tx_ready = 1'b1;
        #1;
        check("t2 head 0x41", {24'h0, tx_data}, 32'h41);
        check("t2 valid", {31'h0, tx_valid}, 32'h1);
        tick();
        check("t2 head 0x42", {24'h0, tx_data}, 32'h42);
        tick();
        check("t2 valid falls", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // 3: overflow, clear, order
        for (int i = 0; i < 9; i++) begin
            bus_write(12'hFF0, 32'h10 + 32'(i));
        end
        bus_read(12'hFF1, rv);
        check("t3 STATUS full+ovf", rv, 32'h0000_0805);
        bus_write(12'hFF1, 32'h0000_0004);
        bus_read(12'hFF1, rv);
        check("t3 STATUS ovf cleared", rv, 32'h0000_0801);
        tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3 order %0d", i), {24'h0, tx_data}, 32'h10 + 32'(i));
            tick();
        end
        check("t3 drained", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // 4: push while full with simultaneous pop
        for (int i = 0; i < 8; i++) begin
            bus_write(12'hFF0, 32'h20 + 32'(i));
        end
        tx_ready = 1'b1;
        bus_write(12'hFF0, 32'h0000_0099);
        tx_ready = 1'b0;
        bus_read(12'hFF1, rv);
        check("t4 STATUS cnt7 ovf", rv, 32'h0000_0704);
        bus_write(12'hFF1, 32'h0000_0004);
        tx_ready = 1'b1;
        #1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t4 order %0d", i), {24'h0, tx_data}, 32'h20 + 32'(i));
            tick();
        end
        check("t4 99 dropped", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // 5: cycle counter
        bus_read(12'hFF2, c1);
        repeat (9) tick();
        bus_read(12'hFF2, rv);
`ifdef MMIO_CYCLE_COUNTER_EN
        check("t5 cycle delta", rv - c1, 32'd10);
        force dut.cycle_reg = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_reg;
        bus_read(12'hFF2, rv);
        check("t5 cycle preload", rv, 32'hFFFF_FFFE);
        bus_read(12'hFF2, rv);
        check("t5 cycle max", rv, 32'hFFFF_FFFF);
        bus_read(12'hFF2, rv);
        check("t5 cycle wrap", rv, 32'h0000_0000);
`else
        check("t5 cycle off first", c1, 32'h0);
        check("t5 cycle off second", rv, 32'h0);
`endif
        bus_write(12'hFF2, 32'hDEAD_BEEF);
        bus_read(12'hFF5, rv);
        check("t5 unmapped reads 0", rv, 32'h0);

        // 6: reset mid-transfer
        for (int i = 0; i < 5; i++) begin
            bus_write(12'hFF0, 32'h30 + 32'(i));
        end
        bus_read(12'hFF1, rv);
        check("t6 STATUS cnt5", rv, 32'h0000_0500);
        #2;
        reset = 1'b1;
        #1;
        check("t6 tx_valid async clear", {31'h0, tx_valid}, 32'h0);
        check("t6 q_dmem=mem_q in reset", q_dmem, mem_q);
        tick();
        reset = 1'b0;
        bus_read(12'hFF1, rv);
        check("t6 STATUS after reset", rv, 32'h0000_0002);
        bus_read(12'h010, rv);
        check("t6 dmem kept", rv, 32'h0000_0123);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
